spi_tx_arbiter: RTL and testbench
=================================

SPI_TX_ARBITER -- requirements
Module: spi_tx_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, default 4: idle clk cycles with spi_onoff low between consecutive bytes, range 1..255.
REQ-002 Parameter TIMEOUT, default 4096: max clk cycles in SEND awaiting spi_valid, range 2..65535.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 a_valid  input  1  requester A offers a byte.
REQ-006 a_data  input  8  requester A byte.
REQ-007 a_dc  input  1  requester A data(1)/command(0) flag.
REQ-008 a_last  input  1  byte ends A's frame; releases lock.
REQ-009 a_ready  output  1  byte accepted from A this cycle.
REQ-010 b_valid, b_data[8], b_dc, b_last, b_ready: same as REQ-005..009 for requester B.
REQ-011 spi_onoff  output  1  start/hold level to SPI master core.
REQ-012 spi_data  output  8  byte to SPI master core.
REQ-013 spi_valid  input  1  one-cycle pulse from core: byte shifted out.
REQ-014 dc  output  1  D/C line for display, flag of byte in flight.
REQ-015 owner  output  1  current/last grantee (0=A, 1=B).
REQ-016 locked  output  1  frame in progress, non-owner blocked.
REQ-017 err_timeout  output  1  sticky: a byte timed out.

Function
REQ-018 States IDLE, SEND, GAP; encoding free.
REQ-019 IDLE, unlocked: grant = the sole valid requester; both valid -> the one not equal to owner (round-robin); grantee's ready=1 combinationally, other ready=0.
REQ-020 IDLE, locked: only owner may be granted; non-owner ready=0 regardless of valid.
REQ-021 ready never asserted outside IDLE; ready=1 only when corresponding valid=1.
REQ-022 On valid&ready: capture data/dc into hold register, owner<=grantee, locked<=!last, next state SEND.
REQ-023 SEND: spi_onoff=1, spi_data=hold byte, dc=hold flag, all stable for whole state; timeout counter cleared on entry, +1 per cycle.
REQ-024 SEND, spi_valid=1: next cycle spi_onoff=0, enter GAP with counter=GAP_CYCLES.
REQ-025 SEND, counter reaches TIMEOUT-1 without spi_valid: err_timeout<=1, locked<=0, enter GAP.
REQ-026 spi_valid and timeout same cycle: treat as success, err_timeout unchanged.
REQ-027 spi_valid outside SEND ignored.
REQ-028 GAP: spi_onoff=0; counter decrements; at 1 -> IDLE; GAP lasts exactly GAP_CYCLES cycles.
REQ-029 Byte latency: handshake cycle N -> spi_onoff high from cycle N+1.
REQ-030 Locked owner with valid=0 holds lock indefinitely; other requester waits.
REQ-031 dc and spi_data hold last value when not in SEND.
REQ-032 err_timeout cleared only by reset.

Reset
REQ-033 reset=1 forces immediately (async): state IDLE, spi_onoff=0, spi_data=0, dc=0, owner=1 (A wins first tie), locked=0, err_timeout=0, counters 0, a_ready=b_ready=0.
REQ-034 Reset mid-SEND aborts byte; no ready asserted until reset released.

Verification
REQ-035 A alone sends 0xE2 dc=1 last=1; core valid 20 cycles later -> spi_onoff high 20 cycles, spi_data=0xE2, dc=1, then low 4 cycles, locked=0.
REQ-036 A and B valid same cycle after reset -> A granted first, B next; repeat tie -> A/B alternate.
REQ-037 A frame 0x01,0x02,0x03 (last on 0x03), B valid throughout -> b_ready=0 until A's 0x03 done; B then granted.
REQ-038 No spi_valid, TIMEOUT=16 -> spi_onoff drops after 16 SEND cycles, err_timeout=1, lock released.
REQ-039 reset pulsed mid-SEND -> spi_onoff=0 same cycle, all outputs at REQ-033 values.
REQ-040 spi_valid coincident with timeout cycle -> err_timeout stays 0.

Source files
------------

// File: rtl/spi_tx_arbiter_if.sv
// Handshake and byte-stream signals between two requesters, the arbiter and
// the SPI master core. The arbiter uses the slave modport. The driving side
// uses the master modport.
interface spi_tx_arbiter_if;
  logic       a_valid;
  logic [7:0] a_data;
  logic       a_dc;
  logic       a_last;
  logic       a_ready;
  logic       b_valid;
  logic [7:0] b_data;
  logic       b_dc;
  logic       b_last;
  logic       b_ready;
  logic       spi_onoff;
  logic [7:0] spi_data;
  logic       spi_valid;
  logic       dc;
  logic       owner;
  logic       locked;
  logic       err_timeout;

  modport slave (
    input  a_valid, a_data, a_dc, a_last,
    output a_ready,
    input  b_valid, b_data, b_dc, b_last,
    output b_ready,
    output spi_onoff, spi_data, dc,
    input  spi_valid,
    output owner, locked, err_timeout
  );

  modport master (
    output a_valid, a_data, a_dc, a_last,
    input  a_ready,
    output b_valid, b_data, b_dc, b_last,
    input  b_ready,
    input  spi_onoff, spi_data, dc,
    output spi_valid,
    input  owner, locked, err_timeout
  );
endinterface

// File: rtl/spi_tx_arbiter.sv
// Two-requester byte arbiter in front of an SPI master core. Frames lock the
// bus to one requester until its last byte is sent. Ties use round-robin.
// Each byte is held stable while the core shifts it out, and a fixed idle
// gap follows each byte.
module spi_tx_arbiter #(
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic             clk,
  input  logic             reset,
  spi_tx_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [15:0] GAP_INIT = 16'(GAP_CYCLES);

  state_t      state;
  logic [15:0] cnt;
  logic        onoff_q;
  logic [7:0]  data_q;
  logic        dc_q;
  logic        owner_q;
  logic        locked_q;
  logic        err_q;
  logic        grant_a;
  logic        grant_b;

  // Grant decision in IDLE. A locked frame admits only its owner, and a tie
  // goes to the requester that was not served last. Reset masks both grants.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state == IDLE && !reset) begin
      if (locked_q) begin
        grant_a = bus.a_valid && !owner_q;
        grant_b = bus.b_valid &&  owner_q;
      end else if (bus.a_valid && bus.b_valid) begin
        grant_a = owner_q;
        grant_b = !owner_q;
      end else begin
        grant_a = bus.a_valid;
        grant_b = bus.b_valid;
      end
    end
  end

  assign bus.a_ready     = grant_a;
  assign bus.b_ready     = grant_b;
  assign bus.spi_onoff   = onoff_q;
  assign bus.spi_data    = data_q;
  assign bus.dc          = dc_q;
  assign bus.owner       = owner_q;
  assign bus.locked      = locked_q;
  assign bus.err_timeout = err_q;

  // Arbiter FSM with all outputs registered. The hold register doubles as
  // spi_data/dc, so both keep their last value outside SEND.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      onoff_q  <= 1'b0;
      data_q   <= '0;
      dc_q     <= 1'b0;
      owner_q  <= 1'b1;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_a || grant_b) begin
            data_q   <= grant_b ? bus.b_data : bus.a_data;
            dc_q     <= grant_b ? bus.b_dc   : bus.a_dc;
            owner_q  <= grant_b;
            locked_q <= grant_b ? !bus.b_last : !bus.a_last;
            onoff_q  <= 1'b1;
            cnt      <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          // A completion that arrives in the timeout cycle counts as success.
          if (bus.spi_valid) begin
            onoff_q <= 1'b0;
            cnt     <= GAP_INIT;
            state   <= GAP;
          end else if (cnt == TO_LAST) begin
            err_q    <= 1'b1;
            locked_q <= 1'b0;
            onoff_q  <= 1'b0;
            cnt      <= GAP_INIT;
            state    <= GAP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        GAP: begin
          if (cnt == 16'd1) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Directed bench for spi_tx_arbiter: a table of single-byte transactions,
// followed by hand-written frame-lock, timeout and reset sequences.
module tb_spi_tx_arbiter;

  localparam int unsigned GAP = 4;
  localparam int unsigned TO  = 24;

  logic clk;
  logic reset;
  int unsigned n_pass;
  int unsigned n_total;

  spi_tx_arbiter_if bus ();

  spi_tx_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic        bv;
    logic [7:0]  ad;
    logic        adc;
    logic        al;
    logic [7:0]  bd;
    logic        bdc;
    logic        bl;
    int unsigned w;     // SEND cycle in which spi_valid is pulsed
    logic        eb;    // expected grantee (1 = B)
    logic [7:0]  ed;
    logic        edc;
    logic        elk;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  // Starts at the first SEND negedge and counts cycles with spi_onoff high.
  // It pulses spi_valid in cycle sv_at (0 = never) and returns at the first
  // GAP negedge.
  task automatic run_send(input int unsigned sv_at, output int unsigned n, output logic stable);
    logic [7:0] d0;
    d0 = bus.spi_data;
    n = 0;
    stable = 1'b1;
    while (bus.spi_onoff === 1'b1 && n < 200) begin
      n++;
      if (bus.spi_data !== d0) stable = 1'b0;
      if (n == sv_at) bus.spi_valid = 1'b1;
      @(negedge clk);
      bus.spi_valid = 1'b0;
    end
  endtask

  // Walks the GAP cycles and counts any ready seen. Ends at the IDLE negedge.
  task automatic gap_wait(output int unsigned bad);
    bad = 0;
    for (int g = 0; g < int'(GAP); g++) begin
      #1;
      if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0 || bus.spi_onoff !== 1'b0) bad++;
      @(negedge clk);
    end
  endtask

  initial begin
    int unsigned n;
    int unsigned bad;
    logic st;

    n_pass = 0;
    n_total = 0;
    reset = 1'b1;
    bus.a_valid = 1'b1; bus.a_data = 8'h00; bus.a_dc = 1'b0; bus.a_last = 1'b0;
    bus.b_valid = 1'b1; bus.b_data = 8'h00; bus.b_dc = 1'b0; bus.b_last = 1'b0;
    bus.spi_valid = 1'b0;

    //               av  bv  ad     adc al  bd     bdc bl  w   eb  ed     edc elk
    vecs[0] = '{1'b1,1'b1,8'h11,1'b0,1'b1,8'h99,1'b1,1'b1, 3,1'b0,8'h11,1'b0,1'b0};
    vecs[1] = '{1'b1,1'b1,8'h22,1'b1,1'b1,8'h33,1'b0,1'b1, 5,1'b1,8'h33,1'b0,1'b0};
    vecs[2] = '{1'b1,1'b1,8'h44,1'b1,1'b1,8'h55,1'b1,1'b1, 1,1'b0,8'h44,1'b1,1'b0};
    vecs[3] = '{1'b0,1'b1,8'h00,1'b0,1'b0,8'hB0,1'b1,1'b0, 2,1'b1,8'hB0,1'b1,1'b1};
    vecs[4] = '{1'b1,1'b1,8'h66,1'b0,1'b1,8'hB1,1'b0,1'b1, 4,1'b1,8'hB1,1'b0,1'b0};
    vecs[5] = '{1'b1,1'b0,8'hE2,1'b1,1'b1,8'h00,1'b0,1'b0,20,1'b0,8'hE2,1'b1,1'b0};

    // Reset state, with both valids held high
    @(negedge clk);
    #1;
    chk("rst_onoff", bus.spi_onoff, 0);
    chk("rst_data", bus.spi_data, 0);
    chk("rst_dc", bus.dc, 0);
    chk("rst_owner", bus.owner, 1);
    chk("rst_locked", bus.locked, 0);
    chk("rst_err", bus.err_timeout, 0);
    chk("rst_a_ready", bus.a_ready, 0);
    chk("rst_b_ready", bus.b_ready, 0);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Table-driven single-byte transactions
    for (int i = 0; i < 6; i++) begin
      bus.a_valid = vecs[i].av; bus.a_data = vecs[i].ad; bus.a_dc = vecs[i].adc; bus.a_last = vecs[i].al;
      bus.b_valid = vecs[i].bv; bus.b_data = vecs[i].bd; bus.b_dc = vecs[i].bdc; bus.b_last = vecs[i].bl;
      #1;
      chk($sformatf("v%0d_a_ready", i), bus.a_ready, !vecs[i].eb);
      chk($sformatf("v%0d_b_ready", i), bus.b_ready, vecs[i].eb);
      @(negedge clk);
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
      chk($sformatf("v%0d_onoff", i), bus.spi_onoff, 1);
      chk($sformatf("v%0d_data", i), bus.spi_data, vecs[i].ed);
      chk($sformatf("v%0d_dc", i), bus.dc, vecs[i].edc);
      chk($sformatf("v%0d_owner", i), bus.owner, vecs[i].eb);
      chk($sformatf("v%0d_locked", i), bus.locked, vecs[i].elk);
      run_send(vecs[i].w, n, st);
      chk($sformatf("v%0d_send_len", i), n, vecs[i].w);
      chk($sformatf("v%0d_stable", i), st, 1);
      chk($sformatf("v%0d_hold_data", i), bus.spi_data, vecs[i].ed);
      gap_wait(bad);
      chk($sformatf("v%0d_gap", i), bad, 0);
    end
    chk("tbl_err", bus.err_timeout, 0);

    // Frame of three bytes from A while B keeps requesting
    for (int i = 0; i < 3; i++) begin
      bus.a_valid = 1'b1; bus.a_data = 8'(i + 1); bus.a_dc = 1'b1; bus.a_last = (i == 2);
      #1;
      chk($sformatf("frm%0d_a_ready", i), bus.a_ready, 1);
      chk($sformatf("frm%0d_b_ready", i), bus.b_ready, 0);
      @(negedge clk);
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b1; bus.b_data = 8'hC3; bus.b_dc = 1'b0; bus.b_last = 1'b1;
      chk($sformatf("frm%0d_data", i), bus.spi_data, i + 1);
      chk($sformatf("frm%0d_locked", i), bus.locked, i != 2);
      run_send(3, n, st);
      chk($sformatf("frm%0d_len", i), n, 3);
      gap_wait(bad);
      chk($sformatf("frm%0d_gap", i), bad, 0);
    end
    #1;
    chk("frm_b_granted", bus.b_ready, 1);
    chk("frm_a_idle", bus.a_ready, 0);
    @(negedge clk);
    bus.b_valid = 1'b0;
    chk("frm_b_owner", bus.owner, 1);
    chk("frm_b_data", bus.spi_data, 8'hC3);
    run_send(2, n, st);
    gap_wait(bad);

    // spi_valid lands in the timeout cycle: success, lock kept
    bus.a_valid = 1'b1; bus.a_data = 8'h77; bus.a_dc = 1'b0; bus.a_last = 1'b0;
    #1;
    chk("coin_a_ready", bus.a_ready, 1);
    @(negedge clk);
    bus.a_valid = 1'b0;
    run_send(TO, n, st);
    chk("coin_len", n, TO);
    chk("coin_err", bus.err_timeout, 0);
    chk("coin_locked", bus.locked, 1);
    gap_wait(bad);

    // Locked owner idle: B must keep waiting
    bus.b_valid = 1'b1;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (bus.b_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("hold_b_blocked", bad, 0);
    chk("hold_locked", bus.locked, 1);

    // No spi_valid at all: timeout releases the lock and sets the sticky error
    bus.a_valid = 1'b1; bus.a_data = 8'h5A; bus.a_last = 1'b0;
    #1;
    chk("to_a_ready", bus.a_ready, 1);
    chk("to_b_ready", bus.b_ready, 0);
    @(negedge clk);
    bus.a_valid = 1'b0;
    run_send(0, n, st);
    chk("to_len", n, TO);
    chk("to_err", bus.err_timeout, 1);
    chk("to_locked", bus.locked, 0);
    chk("to_hold_data", bus.spi_data, 8'h5A);
    gap_wait(bad);
    chk("to_gap", bad, 0);
    #1;
    chk("to_b_granted", bus.b_ready, 1);
    chk("to_err_sticky", bus.err_timeout, 1);

    // Reset in the middle of B's SEND
    @(negedge clk);
    bus.a_valid = 1'b1;
    chk("mid_onoff", bus.spi_onoff, 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_onoff", bus.spi_onoff, 0);
    chk("mid_rst_data", bus.spi_data, 0);
    chk("mid_rst_dc", bus.dc, 0);
    chk("mid_rst_owner", bus.owner, 1);
    chk("mid_rst_locked", bus.locked, 0);
    chk("mid_rst_err", bus.err_timeout, 0);
    chk("mid_rst_a_ready", bus.a_ready, 0);
    chk("mid_rst_b_ready", bus.b_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_a_ready", bus.a_ready, 1);
    chk("post_rst_b_ready", bus.b_ready, 0);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", bus.spi_onoff, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
